// File: rtl/div_pkg.sv
// Shared types and sizes for the iterative divider.
// The default operand width lives here so that the counter width follows it.
package div_pkg;
    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;
endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: lookahead inside 4-bit groups and across the groups.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate/propagate, carries between groups, then carries inside each group
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                c[i] = grp_c[i/4];
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
    end

    assign sum  = p ^ c;
    assign cout = grp_c[4];
endmodule

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// The trial subtraction rem_shifted - D is done as rem_shifted + ~D + 1 on a chain
// of 16-bit lookahead adders wide enough to hold bitwidth+1 bits plus headroom.
module div_step #(
    parameter int bitwidth = 32
) (
    input  logic [bitwidth-1:0] rem,
    input  logic [bitwidth-1:0] quo,
    input  logic [bitwidth-1:0] d,
    output logic [bitwidth-1:0] rem_next,
    output logic [bitwidth-1:0] quo_next
);
    localparam int NBLK  = (bitwidth + 1) / 16 + 1;
    localparam int SUM_W = NBLK * 16;

    logic [bitwidth:0]  rem_shifted;
    logic [SUM_W-1:0]   a_ext;
    logic [SUM_W-1:0]   b_ext;
    logic [SUM_W-1:0]   sum;
    logic [NBLK:0]      carry;
    logic               no_borrow;

    // Shift {rem,quo} left by one: the quotient MSB moves into the partial remainder
    assign rem_shifted = {rem, quo[bitwidth-1]};
    assign a_ext       = SUM_W'(rem_shifted);
    assign b_ext       = ~SUM_W'(d);
    assign carry[0]    = 1'b1;

    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_cla
            CLA_16bit u_cla (
                .a    (a_ext[gi*16 +: 16]),
                .b    (b_ext[gi*16 +: 16]),
                .cin  (carry[gi]),
                .sum  (sum[gi*16 +: 16]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the whole chain means rem_shifted >= D; the difference is then < D,
    // so the bits above bitwidth are zero as well
    assign no_borrow = carry[NBLK] & ~(|sum[SUM_W-1:bitwidth]);

    assign rem_next = no_borrow ? sum[bitwidth-1:0] : rem_shifted[bitwidth-1:0];
    assign quo_next = {quo[bitwidth-2:0], no_borrow};
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider with valid/ready handshakes, one operation in flight.
// Optional feature: define SIGNED_DIV_EN to add the is_signed port and sign fix-up.
module iter_divider
    import div_pkg::*;
#(
    parameter int bitwidth = DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bitwidth-1:0] dividend,
    input  logic [bitwidth-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic                is_signed,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bitwidth-1:0] quotient,
    output logic [bitwidth-1:0] remainder,
    output logic                div_by_zero
);
    div_state_t          state_reg;
    div_state_t          state_next;
    logic [bitwidth-1:0] rem_reg;
    logic [bitwidth-1:0] quo_reg;
    logic [bitwidth-1:0] d_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [bitwidth-1:0] rem_next;
    logic [bitwidth-1:0] quo_next;
    logic [bitwidth-1:0] n_mag;
    logic [bitwidth-1:0] d_mag;
    logic [bitwidth-1:0] q_final;
    logic [bitwidth-1:0] r_final;
    logic                accept;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_ready & in_valid;

    div_step #(.bitwidth(bitwidth)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .d        (d_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

`ifdef SIGNED_DIV_EN
    logic n_neg;
    logic d_neg;
    logic neg_q_reg;
    logic neg_r_reg;

    assign n_neg   = is_signed & dividend[bitwidth-1];
    assign d_neg   = is_signed & divisor[bitwidth-1];
    assign n_mag   = n_neg ? -dividend : dividend;
    assign d_mag   = d_neg ? -divisor : divisor;
    assign q_final = neg_q_reg ? -quo_next : quo_next;
    assign r_final = neg_r_reg ? -rem_next : rem_next;

    // Remember the result signs at accept; the quotient flips on mixed signs,
    // the remainder follows the dividend
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= n_neg ^ d_neg;
            neg_r_reg <= n_neg;
        end
    end
`else
    assign n_mag   = dividend;
    assign d_mag   = divisor;
    assign q_final = quo_next;
    assign r_final = rem_next;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: divide-by-zero skips RUN; the step at count 0 is the last one
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers (held stable in DONE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg     <= '0;
            quo_reg     <= '0;
            d_reg       <= '0;
            count_reg   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        d_reg     <= d_mag;
                        rem_reg   <= '0;
                        quo_reg   <= n_mag;
                        count_reg <= CNT_W'(bitwidth - 1);
                        if (divisor == '0) begin
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (count_reg == '0) begin
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider; SIGNED_DIV_EN adds the signed cases.
module tb_iter_divider;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef SIGNED_DIV_EN
    logic        is_signed;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    iter_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SIGNED_DIV_EN
        .is_signed   (is_signed),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation for one edge, then count edges until out_valid (bounded)
    task automatic start_op(input logic [31:0] n, input logic [31:0] d, input logic s,
                            output int cyc);
        dividend = n;
        divisor  = d;
`ifdef SIGNED_DIV_EN
        is_signed = s;
`else
        if (s) $display("note: signed request issued in unsigned build");
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient got %h want 0", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder got %h want 0", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_basic();
        int cyc;
        start_op(32'd100, 32'd7, 1'b0, cyc);
        n_checks += 4;
        if (cyc !== 33) begin n_fail++; $display("FAIL basic_latency got %0d want 33", cyc); end
        if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q got %0d want 14", quotient); end
        if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_r got %0d want 2", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        $display("op 100/7: cycles=%0d q=%0d r=%0d dbz=%b", cyc, quotient, remainder, div_by_zero);
        take_result();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return_idle got %b want 1", in_ready); end
    endtask

    task automatic test_boundaries();
        int cyc;
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0, cyc);
        n_checks += 3;
        if (cyc !== 33) begin n_fail++; $display("FAIL max_latency got %0d want 33", cyc); end
        if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL max_q got %h want ffffffff", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL max_r got %h want 0", remainder); end
        $display("op ffffffff/1: q=%h r=%h", quotient, remainder);
        take_result();
        start_op(32'd5, 32'd9, 1'b0, cyc);
        n_checks += 2;
        if (quotient !== 32'd0) begin n_fail++; $display("FAIL small_q got %0d want 0", quotient); end
        if (remainder !== 32'd5) begin n_fail++; $display("FAIL small_r got %0d want 5", remainder); end
        $display("op 5/9: q=%0d r=%0d", quotient, remainder);
        take_result();
        start_op(32'd4321, 32'd4321, 1'b0, cyc);
        n_checks += 2;
        if (quotient !== 32'd1) begin n_fail++; $display("FAIL equal_q got %0d want 1", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL equal_r got %0d want 0", remainder); end
        $display("op 4321/4321: q=%0d r=%0d", quotient, remainder);
        take_result();
        start_op(32'h8000_0000, 32'h0000_0003, 1'b0, cyc);
        n_checks += 2;
        if (quotient !== 32'h2AAA_AAAA) begin n_fail++; $display("FAIL big_q got %h want 2aaaaaaa", quotient); end
        if (remainder !== 32'd2) begin n_fail++; $display("FAIL big_r got %0d want 2", remainder); end
        $display("op 80000000/3: q=%h r=%0d", quotient, remainder);
        take_result();
    endtask

    task automatic test_div_zero();
        int cyc;
        start_op(32'd1234, 32'd0, 1'b0, cyc);
        n_checks += 4;
        if (cyc !== 1) begin n_fail++; $display("FAIL dz_latency got %0d want 1", cyc); end
        if (quotient !== 32'd0) begin n_fail++; $display("FAIL dz_q got %0d want 0", quotient); end
        if (remainder !== 32'd1234) begin n_fail++; $display("FAIL dz_r got %0d want 1234", remainder); end
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        $display("op 1234/0: cycles=%0d q=%0d r=%0d dbz=%b", cyc, quotient, remainder, div_by_zero);
        take_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(32'd20, 32'd6, 1'b0, cyc);
        dividend = 32'd77;
        divisor  = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 1", i, out_valid); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
            if (quotient !== 32'd3) begin n_fail++; $display("FAIL hold_q[%0d] got %0d want 3", i, quotient); end
            if (remainder !== 32'd2) begin n_fail++; $display("FAIL hold_r[%0d] got %0d want 2", i, remainder); end
        end
        $display("op 20/6 held 10 cycles: q=%0d r=%0d", quotient, remainder);
        in_valid = 1'b0;
        take_result();
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_idle got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ignored_op got in_ready %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        dividend = 32'd100;
        divisor  = 32'd7;
`ifdef SIGNED_DIV_EN
        is_signed = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL run_busy got in_ready %b want 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        n_checks += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        if (quotient !== 32'd0) begin n_fail++; $display("FAIL midrst_q got %0d want 0", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL midrst_r got %0d want 0", remainder); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        start_op(32'd9, 32'd3, 1'b0, cyc);
        n_checks += 3;
        if (cyc !== 33) begin n_fail++; $display("FAIL after_rst_latency got %0d want 33", cyc); end
        if (quotient !== 32'd3) begin n_fail++; $display("FAIL after_rst_q got %0d want 3", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL after_rst_r got %0d want 0", remainder); end
        $display("op 9/3 after reset: q=%0d r=%0d", quotient, remainder);
        take_result();
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int cyc;
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, cyc);
        n_checks += 3;
        if (cyc !== 33) begin n_fail++; $display("FAIL s_latency got %0d want 33", cyc); end
        if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL s_q got %h want fffffffd", quotient); end
        if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL s_r got %h want ffffffff", remainder); end
        $display("op -7/2 signed: q=%h r=%h", quotient, remainder);
        take_result();
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc);
        n_checks += 2;
        if (quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL s_ovf_q got %h want 80000000", quotient); end
        if (remainder !== 32'd0) begin n_fail++; $display("FAIL s_ovf_r got %h want 0", remainder); end
        $display("op 80000000/-1 signed: q=%h r=%h", quotient, remainder);
        take_result();
        start_op(32'hFFFF_FFF9, 32'd0, 1'b1, cyc);
        n_checks += 3;
        if (quotient !== 32'd0) begin n_fail++; $display("FAIL s_dz_q got %h want 0", quotient); end
        if (remainder !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL s_dz_r got %h want fffffff9", remainder); end
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL s_dz_flag got %b want 1", div_by_zero); end
        $display("op -7/0 signed: q=%h r=%h", quotient, remainder);
        take_result();
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef SIGNED_DIV_EN
        is_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
